// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width and width helpers for FIFO sizing.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Occupancy needs one bit more than the index to represent DEPTH itself.
    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, kept separate so it can be swapped for a vendor RAM.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Unreset contents are never observed: the head is only consumed when valid.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through AXI4-Stream byte FIFO feeding the UART transmitter.
// Optional UART_TX_FIFO_DROP_EN: never stall the producer, drop beats while full and count them.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
`ifdef UART_TX_FIFO_DROP_EN
    output logic [15:0]           overflow_cnt,
`endif
    output logic                  almost_full
);

    localparam int CNT_W = count_width(DEPTH_LOG2);

    logic [DEPTH_LOG2:0]   r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_rd_ptr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DEPTH_LOG2:0]   w_count;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                     (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_count = r_wr_ptr - r_rd_ptr;

`ifdef UART_TX_FIFO_DROP_EN
    assign s_axis_tready = !rst;
`else
    assign s_axis_tready = !w_full && !rst;
`endif

    assign w_wr_en = s_axis_tvalid && s_axis_tready && !w_full;
    assign w_rd_en = m_axis_tready && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

`ifdef UART_TX_FIFO_DROP_EN
    logic [15:0] r_overflow_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow_cnt <= '0;
        end else if (s_axis_tvalid && w_full && (r_overflow_cnt != 16'hFFFF)) begin
            r_overflow_cnt <= r_overflow_cnt + 16'd1;
        end
    end

    assign overflow_cnt = r_overflow_cnt;
`endif

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wr_data (s_axis_tdata),
        .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign m_axis_tdata  = w_rd_data;
    assign m_axis_tvalid = !w_empty;
    assign count         = w_count;
    assign empty         = w_empty;
    assign almost_full   = (w_count >= CNT_W'(AFULL_LEVEL));

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: driver queues accepted bytes, monitor checks them at the m_axis side.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DL:0]   count;
    logic          empty;
    logic          almost_full;
`ifdef UART_TX_FIFO_DROP_EN
    logic [15:0]   overflow_cnt;
`endif

    uart_tx_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH_LOG2  (DL),
        .AFULL_LEVEL (AF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .count         (count),
        .empty         (empty),
`ifdef UART_TX_FIFO_DROP_EN
        .overflow_cnt  (overflow_cnt),
`endif
        .almost_full   (almost_full)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_reads  = 0;
    bit stop_toggle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one beat until accepted; accepted bytes become expected output.
    task automatic write_beat(input logic [DW-1:0] d);
        bit ok;
        ok = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1;
                exp_q.push_back(d);
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        if (!ok) check("wr_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain(input int n);
        m_axis_tready = 1'b1;
        repeat (n) tick();
        m_axis_tready = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("empty_after_drain", 32'(empty), 32'd1);
    endtask

    // Monitor: a handshake seen at negedge completes at the next posedge.
    logic          prev_valid, prev_ready, prev_rst;
    logic [DW-1:0] prev_data;
    initial begin
        prev_valid = 0; prev_ready = 0; prev_rst = 1; prev_data = '0;
    end

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst && !prev_rst && prev_valid && !prev_ready) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_data", 32'(m_axis_tdata), 32'(prev_data));
        end
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data", 32'(m_axis_tdata), 32'(e));
                n_reads++;
            end
        end
        prev_valid = m_axis_tvalid;
        prev_ready = m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_rst   = rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads_before;
        int waited;
        rst = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;

        // Test 1: reset state and first writes.
        tick();
        tick();
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_afull", 32'(almost_full), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", 32'(s_axis_tready), 32'd1);
        check("tvalid_before_wr", 32'(m_axis_tvalid), 32'd0);
        @(posedge clk);
        #1;
        write_beat(8'h41);
        check("tvalid_latency", 32'(m_axis_tvalid), 32'd1);
        check("head_first", 32'(m_axis_tdata), 32'h41);
        write_beat(8'h42);
        write_beat(8'h43);
        check("t1_count", 32'(count), 32'd3);
        check("t1_empty", 32'(empty), 32'd0);
        check("t1_head", 32'(m_axis_tdata), 32'h41);
        drain(3);
        $display("test1 reset/first writes done");

`ifndef UART_TX_FIFO_DROP_EN
        // Test 2 and 4: fill to full, backpressure, read while full.
        for (int i = 0; i < DEPTH; i++) begin
            write_beat(8'(i));
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_afull", 32'(almost_full), 32'((i + 1) >= AF));
        end
        check("full_tready", 32'(s_axis_tready), 32'd0);
        s_axis_tdata  = 8'h10;
        s_axis_tvalid = 1'b1;
        repeat (3) tick();
        check("held_count", 32'(count), 32'd16);
        check("held_tready", 32'(s_axis_tready), 32'd0);
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        check("full_rd_count", 32'(count), 32'd15);
        check("tready_return", 32'(s_axis_tready), 32'd1);
        check("afull_at_15", 32'(almost_full), 32'd1);
        drain(15);
        $display("test2/4 full handling done");
`else
        // Test 6: overflow drops while full.
        for (int i = 0; i < DEPTH; i++) begin
            write_beat(8'(i));
        end
        check("drop_tready", 32'(s_axis_tready), 32'd1);
        s_axis_tdata  = 8'hEE;
        s_axis_tvalid = 1'b1;
        repeat (3) tick();
        s_axis_tvalid = 1'b0;
        check("drop_overflow", 32'(overflow_cnt), 32'd3);
        check("drop_count", 32'(count), 32'd16);
        drain(16);
        $display("test6 drop mode done");
`endif

        // Test 3: streaming 100 beats with a stalling consumer across pointer wrap.
        reads_before = n_reads;
        stop_toggle  = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    write_beat(8'((i * 37 + 5) & 8'hFF));
                end
                stop_toggle = 1;
            end
            begin
                while (!stop_toggle) begin
                    @(posedge clk);
                    #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_axis_tready = 1'b1;
        waited = 0;
        while (!empty && waited < 100) begin
            tick();
            waited++;
        end
        m_axis_tready = 1'b0;
        check("stream_reads", 32'(n_reads - reads_before), 32'd100);
        check("stream_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test3 streaming done");

        // Test 5: reset with entries queued.
        for (int i = 0; i < 5; i++) begin
            write_beat(8'hA0 + 8'(i));
        end
        check("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tready", 32'(s_axis_tready), 32'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_mid_tready2", 32'(s_axis_tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 32'(s_axis_tready), 32'd1);
        @(posedge clk);
        #1;
        write_beat(8'h55);
        check("post_rst_head", 32'(m_axis_tdata), 32'h55);
        check("post_rst_count", 32'(count), 32'd1);
        drain(1);
        $display("test5 mid-run reset done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
